// File: rtl/lcd_frame_sched.sv
// Frame scheduler and bus arbiter for an ILI9341 8-bit 8080 write bus.
// A tearing-effect rising edge starts a frame. The frame is an 11-byte
// CASET/PASET/RAMWR header followed by WIDTH*HEIGHT RGB565 pixels, sent
// high byte first. Between frames the bus belongs to the host command
// port, which can send one byte per cycle.
// Bus outputs are registered single-cycle strobes. A downstream stage
// generates the physical active-low WE timing.
module lcd_frame_sched #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        lcd_fmark,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_we,
    output logic        pix_ready,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        cmd_valid,
    input  logic        cmd_rs,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        skipped
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);

    // Window corners, computed with 16-bit wrap-around arithmetic.
    localparam logic [15:0]   X0_W   = 16'(X0);
    localparam logic [15:0]   X1_W   = 16'(X0 + WIDTH - 1);
    localparam logic [15:0]   Y0_W   = 16'(Y0);
    localparam logic [15:0]   Y1_W   = 16'(Y0 + HEIGHT - 1);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

    typedef enum logic [1:0] {IDLE, HDR, PIX_HI, PIX_LO} state_t;

    state_t        state_reg;
    logic [2:0]    sync_reg;      // [0],[1] synchronizer, [2] edge-detect history
    logic          pend_reg;
    logic [3:0]    hdr_idx_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    pix_lo_reg;
    logic [7:0]    lcd_data_reg;
    logic          lcd_rs_reg;
    logic          lcd_we_reg;
    logic          frame_done_reg;
    logic          underrun_reg;
    logic          skipped_reg;

    logic          rise;
    logic          start;
    logic [CW-1:0] cnt_next;

    // Header ROM. Each entry is {rs, byte}, indexed by position in the header.
    function automatic logic [8:0] hdr_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_entry = {1'b0, 8'h2A};
            4'd1:    hdr_entry = {1'b1, X0_W[15:8]};
            4'd2:    hdr_entry = {1'b1, X0_W[7:0]};
            4'd3:    hdr_entry = {1'b1, X1_W[15:8]};
            4'd4:    hdr_entry = {1'b1, X1_W[7:0]};
            4'd5:    hdr_entry = {1'b0, 8'h2B};
            4'd6:    hdr_entry = {1'b1, Y0_W[15:8]};
            4'd7:    hdr_entry = {1'b1, Y0_W[7:0]};
            4'd8:    hdr_entry = {1'b1, Y1_W[15:8]};
            4'd9:    hdr_entry = {1'b1, Y1_W[7:0]};
            4'd10:   hdr_entry = {1'b0, 8'h2C};
            default: hdr_entry = {1'b0, 8'h2C};
        endcase
    endfunction

    // Rising edge of the synchronized tearing-effect signal. A frame start
    // wins the bus over the host port in the same cycle.
    always_comb begin
        rise      = sync_reg[1] & ~sync_reg[2];
        start     = (state_reg == IDLE) & (pend_reg | (rise & enable));
        cnt_next  = cnt_reg + CW'(1);
        cmd_ready = (state_reg == IDLE) & ~start & ~rst;
        pix_ready = (state_reg == PIX_HI) & ~rst;
        busy      = (state_reg != IDLE);
    end

    // Two-flop synchronizer for the asynchronous fmark input, plus one
    // history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], lcd_fmark};
        end
    end

    // Main scheduler. Sequences the states and registers every bus byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pend_reg       <= 1'b0;
            hdr_idx_reg    <= 4'd0;
            cnt_reg        <= '0;
            pix_lo_reg     <= 8'h00;
            lcd_data_reg   <= 8'h00;
            lcd_rs_reg     <= 1'b0;
            lcd_we_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            skipped_reg    <= 1'b0;
        end else begin
            lcd_we_reg     <= 1'b0;
            frame_done_reg <= 1'b0;

            // An edge that arrives mid-frame is dropped; only the flag records it.
            if (rise && state_reg != IDLE) begin
                skipped_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (rise && enable) begin
                        pend_reg <= 1'b1;
                    end
                    if (start) begin
                        state_reg    <= HDR;
                        pend_reg     <= 1'b0;
                        hdr_idx_reg  <= 4'd0;
                        cnt_reg      <= '0;
                        underrun_reg <= 1'b0;
                    end else if (cmd_valid) begin
                        lcd_data_reg <= cmd_data;
                        lcd_rs_reg   <= cmd_rs;
                        lcd_we_reg   <= 1'b1;
                    end
                end
                HDR: begin
                    {lcd_rs_reg, lcd_data_reg} <= hdr_entry(hdr_idx_reg);
                    lcd_we_reg                 <= 1'b1;
                    if (hdr_idx_reg == 4'd10) begin
                        state_reg <= PIX_HI;
                    end else begin
                        hdr_idx_reg <= hdr_idx_reg + 4'd1;
                    end
                end
                PIX_HI: begin
                    if (pix_valid) begin
                        pix_lo_reg   <= pix_data[7:0];
                        lcd_data_reg <= pix_data[15:8];
                        lcd_rs_reg   <= 1'b1;
                        lcd_we_reg   <= 1'b1;
                        state_reg    <= PIX_LO;
                    end else begin
                        underrun_reg <= 1'b1;
                    end
                end
                PIX_LO: begin
                    lcd_data_reg <= pix_lo_reg;
                    lcd_rs_reg   <= 1'b1;
                    lcd_we_reg   <= 1'b1;
                    cnt_reg      <= cnt_next;
                    if (cnt_next == NPIX_C) begin
                        frame_done_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end else begin
                        state_reg <= PIX_HI;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign lcd_data   = lcd_data_reg;
    assign lcd_rs     = lcd_rs_reg;
    assign lcd_we     = lcd_we_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;
    assign skipped    = skipped_reg;

endmodule
